// File: rtl/fpu_compare_sequencer_if.sv
// fpu_compare_sequencer_if: dispatch, register-stack, comparator and status-word signals of the compare sequencer
interface fpu_compare_sequencer_if #(
  parameter int DATA_W = 80
);
  logic              execute;
  logic [7:0]        instruction;
  logic [2:0]        stack_index;
  logic              im_mask;
  logic [2:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_empty;
  logic              cmp_start;
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_done;
  logic [1:0]        cmp_res;
  logic              cc_write;
  logic [3:0]        cc;
  logic              exc_valid;
  logic              exc_ie;
  logic              exc_sf;
  logic              exc_de;
  logic              pop;
  logic              ready;
  logic              error;
  modport slave (
    input  execute, instruction, stack_index, im_mask, rd_data, rd_empty, cmp_done, cmp_res,
    output rd_addr, cmp_start, cmp_a, cmp_b, cc_write, cc, exc_valid, exc_ie, exc_sf, exc_de,
           pop, ready, error
  );
  modport master (
    output execute, instruction, stack_index, im_mask, rd_data, rd_empty, cmp_done, cmp_res,
    input  rd_addr, cmp_start, cmp_a, cmp_b, cc_write, cc, exc_valid, exc_ie, exc_sf, exc_de,
           pop, ready, error
  );
endinterface

// File: rtl/fpu_compare_sequencer.sv
// fpu_compare_sequencer: sequences FCOM/FCOMP/FCOMPP/FTST/FXAM through stack reads, the shared comparator, C3..C0 and pops
module fpu_compare_sequencer #(
  parameter int         DATA_W      = 80,
  parameter int         CMP_TIMEOUT = 16,
  parameter logic [7:0] OPC_FCOM    = 8'h60,
  parameter logic [7:0] OPC_FCOMP   = 8'h61,
  parameter logic [7:0] OPC_FCOMPP  = 8'h62,
  parameter logic [7:0] OPC_FTST    = 8'h63,
  parameter logic [7:0] OPC_FXAM    = 8'h64
) (
  input logic                   clk,
  input logic                   reset,
  fpu_compare_sequencer_if.slave bus
);
  localparam int CW = $clog2(CMP_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RDA, RDB, CMP, WAIT, CC, POP1, POP2} state_t;
  state_t            state, state_n;
  logic [7:0]        op;
  logic [2:0]        idx;
  logic              mask;
  logic              ea;
  logic              err_op;
  logic [CW-1:0]     cnt;
  logic              opc_ok;
  logic              is_fcomp;
  logic              is_fcompp;
  logic              is_ftst;
  logic              is_fxam;
  logic              e_any;
  logic [DATA_W-1:0] b_n;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return x[78:64] == 15'h7fff && x[62:0] != '0;
  endfunction

  function automatic logic is_den(input logic [DATA_W-1:0] x);
    return x[78:64] == '0 && x[63:0] != '0;
  endfunction

  // class code {C3,C2,C0} from exponent/mantissa; C1 always carries the sign
  function automatic logic [3:0] fxam_cc(input logic [DATA_W-1:0] x, input logic e);
    logic [2:0] k;
    k = e ? 3'b101 :
        x[78:64] == '0 ? (x[63:0] == '0 ? 3'b100 : 3'b110) :
        x[78:64] == 15'h7fff ? (x[62:0] != '0 ? 3'b001 : x[63] ? 3'b011 : 3'b000) :
        x[63] ? 3'b010 : 3'b000;
    return {k[2], k[1], x[79], k[0]};
  endfunction

  function automatic logic [3:0] res_cc(input logic [1:0] r);
    return r == 2'b00 ? 4'b0000 : r == 2'b01 ? 4'b0001 : r == 2'b10 ? 4'b1000 : 4'b1101;
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // next state, handshake pulses and operand-B selection
  always_comb begin
    opc_ok = bus.instruction == OPC_FCOM || bus.instruction == OPC_FCOMP ||
             bus.instruction == OPC_FCOMPP || bus.instruction == OPC_FTST ||
             bus.instruction == OPC_FXAM;
    is_fcomp = op == OPC_FCOMP;
    is_fcompp = op == OPC_FCOMPP;
    is_ftst = op == OPC_FTST;
    is_fxam = op == OPC_FXAM;
    b_n = is_ftst ? '0 : bus.rd_data;
    e_any = ea || (!is_ftst && bus.rd_empty);
    state_n = state;
    bus.ready = 1'b0;
    bus.pop = 1'b0;
    bus.cc_write = 1'b0;
    bus.exc_valid = 1'b0;
    bus.error = err_op;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.execute && opc_ok) state_n = RDA;
      end
      RDA: state_n = RDB;
      RDB: state_n = is_fxam ? CC : CMP;
      CMP: state_n = e_any ? CC : WAIT;
      WAIT: begin
        if (bus.cmp_done) state_n = CC;
        else if (cnt == '0) begin
          state_n = IDLE;
          bus.error = 1'b1;
        end
      end
      CC: begin
        bus.cc_write = 1'b1;
        bus.exc_valid = bus.exc_ie || bus.exc_sf || bus.exc_de;
        bus.error = bus.exc_ie && !mask;
        state_n = bus.error ? IDLE : (is_fcomp || is_fcompp) ? POP1 : IDLE;
      end
      POP1: begin
        bus.pop = 1'b1;
        state_n = is_fcompp ? POP2 : IDLE;
      end
      POP2: begin
        bus.pop = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // operand capture, read address, comparator launch, timeout counter and C3..C0/exception registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= '0;
      idx <= '0;
      mask <= 1'b0;
      ea <= 1'b0;
      err_op <= 1'b0;
      cnt <= '0;
      bus.rd_addr <= '0;
      bus.cmp_start <= 1'b0;
      bus.cmp_a <= '0;
      bus.cmp_b <= '0;
      bus.cc <= '0;
      bus.exc_ie <= 1'b0;
      bus.exc_sf <= 1'b0;
      bus.exc_de <= 1'b0;
    end else begin
      bus.cmp_start <= state == CMP && !e_any;
      err_op <= state == IDLE && bus.execute && !opc_ok;
      if (state == IDLE && bus.execute && opc_ok) begin
        op <= bus.instruction;
        idx <= bus.stack_index;
        mask <= bus.im_mask;
        bus.rd_addr <= '0;
        bus.exc_ie <= 1'b0;
        bus.exc_sf <= 1'b0;
        bus.exc_de <= 1'b0;
      end
      if (state == RDA) bus.rd_addr <= is_fcompp ? 3'd1 : (is_ftst || is_fxam) ? 3'd0 : idx;
      if (state == RDB) begin
        bus.cmp_a <= bus.rd_data;
        ea <= bus.rd_empty;
        if (is_fxam) bus.cc <= fxam_cc(bus.rd_data, bus.rd_empty);
      end
      if (state == CMP) begin
        bus.cmp_b <= b_n;
        cnt <= CW'(CMP_TIMEOUT);
        bus.exc_ie <= e_any || is_nan(bus.cmp_a) || is_nan(b_n);
        bus.exc_sf <= e_any;
        bus.exc_de <= !e_any && (is_den(bus.cmp_a) || is_den(b_n));
        if (e_any) bus.cc <= 4'b1101;
      end
      if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        if (bus.cmp_done) bus.cc <= res_cc(bus.cmp_res);
      end
    end
  end
endmodule

// File: tb/tb_fpu_compare_sequencer.sv
// tb_fpu_compare_sequencer: directed bench with stack/comparator models and a cc scoreboard
module tb_fpu_compare_sequencer;
  localparam logic [79:0] ONE   = 80'h3fff_8000_0000_0000_0000;
  localparam logic [79:0] TWO   = 80'h4000_8000_0000_0000_0000;
  localparam logic [79:0] HALF  = 80'h3ffe_8000_0000_0000_0000;
  localparam logic [79:0] QTR   = 80'h3ffd_8000_0000_0000_0000;
  localparam logic [79:0] MONE  = 80'hbfff_8000_0000_0000_0000;
  localparam logic [79:0] MTWO  = 80'hc000_8000_0000_0000_0000;
  localparam logic [79:0] QNAN  = 80'h7fff_c000_0000_0000_0000;
  localparam logic [79:0] DEN   = 80'h0000_4000_0000_0000_0000;
  localparam logic [79:0] PINF  = 80'h7fff_8000_0000_0000_0000;

  logic clk = 0;
  logic reset;
  int   cyc = 0;
  int   pass_n = 0;
  int   total_n = 0;
  int   cmp_lat = 1;
  int   pop_n, err_n, start_n, cw_n;
  int   pop_first, pop_last, err_cyc, start_cyc;
  int   n;
  logic [79:0] st [8];
  logic        emp [8];
  logic [7:0]  sb [$];

  fpu_compare_sequencer_if #(.DATA_W(80)) bus ();

  fpu_compare_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bus.rd_data <= st[bus.rd_addr];
    bus.rd_empty <= emp[bus.rd_addr];
  end

  function automatic logic nan80(input logic [79:0] x);
    return x[78:64] == 15'h7fff && x[62:0] != 63'd0;
  endfunction

  function automatic logic [1:0] fp_cmp(input logic [79:0] a, input logic [79:0] b);
    if (nan80(a) || nan80(b)) return 2'b11;
    if (a[78:0] == 79'd0 && b[78:0] == 79'd0) return 2'b10;
    if (a[79] != b[79]) return a[79] ? 2'b01 : 2'b00;
    if (a[78:0] == b[78:0]) return 2'b10;
    return ((a[78:0] > b[78:0]) ^ a[79]) ? 2'b00 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [1:0] res;
    bus.cmp_done = 1'b0;
    bus.cmp_res = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.cmp_start === 1'b1 && cmp_lat > 0) begin
        res = fp_cmp(bus.cmp_a, bus.cmp_b);
        repeat (cmp_lat) @(posedge clk);
        #1 bus.cmp_done = 1'b1;
        bus.cmp_res = res;
        @(posedge clk);
        #1 bus.cmp_done = 1'b0;
        bus.cmp_res = 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.cc_write === 1'b1) begin
      cw_n++;
      if (sb.size() > 0)
        check("cc/flags", {bus.cc, bus.exc_valid, bus.exc_ie, bus.exc_sf, bus.exc_de}, sb.pop_front());
    end
    if (bus.pop === 1'b1) begin
      if (pop_n == 0) pop_first = cyc;
      pop_last = cyc;
      pop_n++;
    end
    if (bus.error === 1'b1) begin
      err_n++;
      err_cyc = cyc;
    end
    if (bus.cmp_start === 1'b1) begin
      start_n++;
      start_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic run(input logic [7:0] opc, input logic [2:0] i, input logic m, input int lat,
                     input logic push, input logic [7:0] exp_sb, input int exp_lat,
                     input int exp_pops, input int exp_err, input int exp_starts, input string tag);
    cmp_lat = lat;
    pop_n = 0;
    err_n = 0;
    start_n = 0;
    cw_n = 0;
    if (push) sb.push_back(exp_sb);
    @(negedge clk);
    bus.execute = 1'b1;
    bus.instruction = opc;
    bus.stack_index = i;
    bus.im_mask = m;
    @(posedge clk);
    #1 bus.execute = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " pops"}, pop_n, exp_pops);
    check({tag, " errors"}, err_n, exp_err);
    check({tag, " cmp_starts"}, start_n, exp_starts);
    check({tag, " cc_writes"}, cw_n, {31'd0, push});
  endtask

  initial begin
    reset = 1'b1;
    bus.execute = 1'b0;
    bus.instruction = 8'h00;
    bus.stack_index = 3'd0;
    bus.im_mask = 1'b0;
    for (int i = 0; i < 8; i++) begin
      st[i] = ONE;
      emp[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", bus.ready, 1);
    check("rst cc", bus.cc, 0);
    check("rst rd_addr", bus.rd_addr, 0);
    check("rst cmp_a", bus.cmp_a, 0);
    check("rst cmp_b", bus.cmp_b, 0);
    check("rst pulses", {bus.cmp_start, bus.cc_write, bus.exc_valid, bus.pop, bus.error}, 0);
    check("rst flags", {bus.exc_ie, bus.exc_sf, bus.exc_de}, 0);
    reset = 1'b0;
    st[0] = TWO; st[1] = ONE;
    run(8'h60, 3'd1, 1'b1, 1, 1'b1, 8'h00, 6, 0, 0, 1, "fcom gt");
    st[0] = HALF; st[1] = ONE; st[5] = QTR;
    run(8'h62, 3'd5, 1'b1, 1, 1'b1, 8'h10, 8, 2, 0, 1, "fcompp lt");
    check("fcompp pop spacing", pop_last - pop_first, 1);
    st[0] = QNAN; st[1] = ONE;
    run(8'h60, 3'd1, 1'b1, 1, 1'b1, 8'hdc, 6, 0, 0, 1, "nan masked");
    run(8'h61, 3'd1, 1'b0, 1, 1'b1, 8'hdc, 6, 0, 1, 1, "nan unmasked");
    st[0] = ONE; emp[1] = 1'b1;
    run(8'h61, 3'd1, 1'b1, 1, 1'b1, 8'hde, 5, 1, 0, 0, "fcomp empty");
    emp[1] = 1'b0;
    st[0] = MONE;
    run(8'h64, 3'd0, 1'b1, 1, 1'b1, 8'h60, 3, 0, 0, 0, "fxam -1");
    st[0] = 80'd0;
    run(8'h64, 3'd0, 1'b1, 1, 1'b1, 8'h80, 3, 0, 0, 0, "fxam +0");
    st[0] = DEN;
    run(8'h64, 3'd0, 1'b1, 1, 1'b1, 8'hc0, 3, 0, 0, 0, "fxam denormal");
    st[0] = PINF;
    run(8'h64, 3'd0, 1'b1, 1, 1'b1, 8'h50, 3, 0, 0, 0, "fxam +inf");
    st[0] = 80'd0; emp[0] = 1'b1;
    run(8'h64, 3'd0, 1'b1, 1, 1'b1, 8'h90, 3, 0, 0, 0, "fxam empty");
    emp[0] = 1'b0;
    st[0] = MTWO; st[2] = MONE;
    run(8'h63, 3'd2, 1'b1, 3, 1'b1, 8'h10, 8, 0, 0, 1, "ftst neg");
    st[0] = DEN; st[3] = ONE;
    run(8'h60, 3'd3, 1'b1, 1, 1'b1, 8'h19, 6, 0, 0, 1, "fcom denormal");
    st[0] = ONE; st[2] = ONE;
    run(8'h60, 3'd2, 1'b1, 2, 1'b1, 8'h80, 7, 0, 0, 1, "fcom eq");
    run(8'h65, 3'd1, 1'b1, 1, 1'b0, 8'h00, 0, 0, 1, 0, "bad opcode");
    st[0] = TWO; st[1] = ONE;
    run(8'h60, 3'd1, 1'b1, 16, 1'b1, 8'h00, 21, 0, 0, 1, "done at expiry");
    run(8'h60, 3'd1, 1'b1, -1, 1'b0, 8'h00, 20, 0, 1, 1, "timeout");
    check("timeout distance", err_cyc - start_cyc, 16);
    cmp_lat = -1;
    pop_n = 0;
    err_n = 0;
    start_n = 0;
    cw_n = 0;
    @(negedge clk);
    bus.execute = 1'b1;
    bus.instruction = 8'h61;
    bus.stack_index = 3'd1;
    bus.im_mask = 1'b1;
    @(posedge clk);
    #1 bus.execute = 1'b0;
    n = 0;
    while (start_n == 0 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("wait-reset cmp_start seen", start_n, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("wait-reset ready", bus.ready, 1);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wait-reset pops", pop_n, 0);
    check("wait-reset cc_writes", cw_n, 0);
    check("wait-reset errors", err_n, 0);
    run(8'h60, 3'd1, 1'b1, 1, 1'b1, 8'h00, 6, 0, 0, 1, "after reset");
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
